// File: rtl/dcpu_bus_pkg.sv
// Shared definitions for the dcpu memory-bus arbiter and its helpers.
package dcpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam int NUM_MASTERS     = 2;
  localparam int DEFAULT_TIMEOUT = 255;

  // Round-robin tie break: the master that did not own the bus last time wins.
  function automatic state_t rr_pick(input logic last);
    return last ? GNT0 : GNT1;
  endfunction

endpackage

// File: rtl/dcpu_bus_timer.sv
// Saturating wait counter; expired holds while the count sits at LIMIT.
module dcpu_bus_timer
#(
  parameter int TW    = 8,
  parameter int LIMIT = 255
)(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TW-1:0] LIM = LIMIT[TW-1:0];

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear)
      r_cnt <= '0;
    else if (i_enable && r_cnt != LIM)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// Two-master round-robin arbiter for the dcpu bus with a per-grant watchdog.
module dcpu_bus_arbiter
  import dcpu_bus_pkg::*;
#(
  parameter int W       = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = 8
)(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_m0_addr,
  input  logic [W-1:0] i_m0_dat,
  input  logic         i_m0_we,
  input  logic         i_m0_cs,
  input  logic [W-1:0] i_m1_addr,
  input  logic [W-1:0] i_m1_dat,
  input  logic         i_m1_we,
  input  logic         i_m1_cs,
  output logic [W-1:0] o_m0_dat,
  output logic         o_m0_ack,
  output logic [W-1:0] o_m1_dat,
  output logic         o_m1_ack,
  output logic [W-1:0] o_addr,
  output logic [W-1:0] o_dat,
  output logic         o_we,
  output logic         o_cs,
  input  logic [W-1:0] i_dat,
  input  logic         i_ack,
  output logic         o_timeout,
  output logic         o_err
);

  state_t r_state;
  logic   r_last;
  logic   r_err;

  logic [NUM_MASTERS-1:0][W-1:0] m_addr, m_wdat, m_rdat;
  logic [NUM_MASTERS-1:0]        m_we, m_cs, m_ack;

  assign m_addr = {i_m1_addr, i_m0_addr};
  assign m_wdat = {i_m1_dat,  i_m0_dat};
  assign m_we   = {i_m1_we,   i_m0_we};
  assign m_cs   = {i_m1_cs,   i_m0_cs};

  logic granted, sel, req, expired, hit_ack, hit_to;

  assign granted = (r_state == GNT0) || (r_state == GNT1);
  assign sel     = (r_state == GNT1);
  assign req     = granted & m_cs[sel];
  assign hit_ack = req & i_ack;
  // Ack wins over an expiry landing in the same cycle.
  assign hit_to  = req & ~i_ack & expired;

  dcpu_bus_timer #(.TW(TW), .LIMIT(TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (~granted),
    .i_enable  (granted),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      if (hit_to)
        r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (m_cs[0] && m_cs[1]) begin
            r_state <= rr_pick(r_last);
            r_last  <= ~r_last;
          end else if (m_cs[0]) begin
            r_state <= GNT0;
            r_last  <= 1'b0;
          end else if (m_cs[1]) begin
            r_state <= GNT1;
            r_last  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!req || hit_ack || hit_to)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Everything is quiet while reset is held, even if a grant was in flight.
  always_comb begin
    o_addr    = '0;
    o_dat     = '0;
    o_we      = 1'b0;
    o_cs      = 1'b0;
    o_timeout = 1'b0;
    m_ack     = '0;
    m_rdat    = '0;
    if (granted && !i_reset) begin
      o_addr       = m_addr[sel];
      o_dat        = m_wdat[sel];
      o_we         = m_we[sel];
      o_cs         = req & ~hit_to;
      o_timeout    = hit_to;
      m_ack[sel]   = hit_ack | hit_to;
      m_rdat[sel]  = hit_ack ? i_dat : '0;
    end
  end

  assign o_m0_ack = m_ack[0];
  assign o_m1_ack = m_ack[1];
  assign o_m0_dat = m_rdat[0];
  assign o_m1_dat = m_rdat[1];
  assign o_err    = r_err & ~i_reset;

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Bench for dcpu_bus_arbiter: directed vector table, hand sequences, random vs model.
module tb_dcpu_bus_arbiter;
  localparam int W  = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] m0_addr, m1_addr, m0_dat, m1_dat, s_dat;
  logic         m0_we, m1_we, m0_cs, m1_cs, s_ack;
  logic [W-1:0] o_m0_dat, o_m1_dat, o_addr, o_dat;
  logic         o_m0_ack, o_m1_ack, o_we, o_cs, o_timeout, o_err;

  dcpu_bus_arbiter #(.W(W), .TIMEOUT(TO), .TW(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_addr(m0_addr), .i_m0_dat(m0_dat), .i_m0_we(m0_we), .i_m0_cs(m0_cs),
    .i_m1_addr(m1_addr), .i_m1_dat(m1_dat), .i_m1_we(m1_we), .i_m1_cs(m1_cs),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
    .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs),
    .i_dat(s_dat), .i_ack(s_ack), .o_timeout(o_timeout), .o_err(o_err)
  );

  typedef struct {
    logic cs, we, ack0, ack1, to, err;
    logic [W-1:0] addr, dat, md0, md1;
  } exp_t;

  typedef struct {
    logic rst, c0, c1, ack;
    logic [W-1:0] sdat;
    logic cs;
    int   gnt;
    logic a0, a1;
    logic [W-1:0] rdat;
    logic to, err;
  } vec_t;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".cs"},   W'(o_cs),      W'(e.cs));
    chk({tag, ".we"},   W'(o_we),      W'(e.we));
    chk({tag, ".addr"}, o_addr,        e.addr);
    chk({tag, ".dat"},  o_dat,         e.dat);
    chk({tag, ".ack0"}, W'(o_m0_ack),  W'(e.ack0));
    chk({tag, ".ack1"}, W'(o_m1_ack),  W'(e.ack1));
    chk({tag, ".md0"},  o_m0_dat,      e.md0);
    chk({tag, ".md1"},  o_m1_dat,      e.md1);
    chk({tag, ".to"},   W'(o_timeout), W'(e.to));
    chk({tag, ".err"},  W'(o_err),     W'(e.err));
  endtask

  // Reference model: who owns the bus, who owned it last, cycles spent waiting.
  int owner = -1, last = 1, waited = 0;
  bit err_flag = 0;
  int nx_owner, nx_last, nx_waited;
  bit nx_err;

  task automatic model_eval(output exp_t e);
    logic [W-1:0] a[2], d[2];
    logic         we[2], cs[2];
    int x;
    a[0] = m0_addr; a[1] = m1_addr; d[0] = m0_dat; d[1] = m1_dat;
    we[0] = m0_we;  we[1] = m1_we;  cs[0] = m0_cs; cs[1] = m1_cs;
    e = '{default: 0};
    nx_owner = -1; nx_last = last; nx_waited = 0; nx_err = err_flag;
    if (rst) begin
      nx_last = 1; nx_err = 0;
      return;
    end
    e.err = err_flag;
    if (owner < 0) begin
      if (cs[0] && cs[1]) nx_owner = 1 - last;
      else if (cs[0])     nx_owner = 0;
      else if (cs[1])     nx_owner = 1;
      if (nx_owner >= 0) nx_last = nx_owner;
    end else begin
      x = owner;
      e.addr = a[x]; e.dat = d[x]; e.we = we[x];
      if (cs[x]) begin
        if (s_ack || waited == TO) begin
          if (s_ack) e.cs = 1;
          else begin e.to = 1; nx_err = 1; end
          if (x == 0) begin e.ack0 = 1; e.md0 = s_ack ? s_dat : '0; end
          else        begin e.ack1 = 1; e.md1 = s_ack ? s_dat : '0; end
        end else begin
          e.cs = 1; nx_owner = x; nx_waited = waited + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    owner = nx_owner; last = nx_last; waited = nx_waited; err_flag = nx_err;
  endtask

  function automatic vec_t v(input logic r, c0, c1, ack, input logic [W-1:0] sdat,
                             input logic cs, input int gnt, input logic a0, a1,
                             input logic [W-1:0] rdat, input logic to, err);
    vec_t t;
    t.rst = r; t.c0 = c0; t.c1 = c1; t.ack = ack; t.sdat = sdat;
    t.cs = cs; t.gnt = gnt; t.a0 = a0; t.a1 = a1; t.rdat = rdat; t.to = to; t.err = err;
    return t;
  endfunction

  function automatic vec_t idle(input logic c0, c1, err);
    return v(0, c0, c1, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, err);
  endfunction

  vec_t tbl[$];
  exp_t e, me;
  int   n_to, n_ack;
  bit   req[2];
  logic [W-1:0] ra[2], rd[2];
  logic rw[2];

  initial begin
    rst = 1; s_ack = 0; s_dat = '0;
    m0_cs = 0; m1_cs = 0;
    m0_addr = 16'h0010; m0_dat = 16'hC0DE; m0_we = 0;
    m1_addr = 16'h0200; m1_dat = 16'h1234; m1_we = 1;
    @(posedge clk); #1;

    // m0 read alone
    tbl.push_back(v(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0));
    tbl.push_back(idle(1, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 16'hBEEF, 1, 1, 1, 0, 16'hBEEF, 0, 0));
    tbl.push_back(idle(0, 0, 0));
    // tie after reset, then alternation m0,m1,m0,m1
    tbl.push_back(v(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0));
    tbl.push_back(idle(1, 1, 0));
    tbl.push_back(v(0, 1, 1, 1, 16'h1111, 1, 1, 1, 0, 16'h1111, 0, 0));
    tbl.push_back(idle(1, 1, 0));
    tbl.push_back(v(0, 1, 1, 1, 16'h2222, 1, 2, 0, 1, 16'h2222, 0, 0));
    tbl.push_back(idle(1, 1, 0));
    tbl.push_back(v(0, 1, 1, 1, 16'h3333, 1, 1, 1, 0, 16'h3333, 0, 0));
    tbl.push_back(idle(1, 1, 0));
    tbl.push_back(v(0, 1, 1, 1, 16'h4444, 1, 2, 0, 1, 16'h4444, 0, 0));
    tbl.push_back(idle(0, 0, 0));
    // m1 write with 3 wait cycles
    tbl.push_back(idle(0, 1, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 0, 1, 0, 16'h0, 1, 2, 0, 0, 16'h0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1, 16'hAAAA, 1, 2, 0, 1, 16'hAAAA, 0, 0));
    tbl.push_back(idle(0, 0, 0));
    // timeout: forced ack in the 5th grant cycle
    tbl.push_back(idle(1, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 16'h0, 0, 1, 1, 0, 16'h0, 1, 0));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    // ack coincides with expiry
    tbl.push_back(idle(1, 0, 1));
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 0, 1));
    tbl.push_back(v(0, 1, 0, 1, 16'h5A5A, 1, 1, 1, 0, 16'h5A5A, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    // reset mid-grant, then fresh m1 request
    tbl.push_back(idle(1, 0, 1));
    tbl.push_back(v(0, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 0, 1));
    tbl.push_back(v(1, 1, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0));
    tbl.push_back(idle(0, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 16'h7777, 1, 2, 0, 1, 16'h7777, 0, 0));
    tbl.push_back(idle(0, 0, 0));
    // abort: m0 drops cs mid-grant
    tbl.push_back(idle(1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 16'h0, 0, 1, 0, 0, 16'h0, 0, 0));
    tbl.push_back(idle(0, 0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; m0_cs = tbl[i].c0; m1_cs = tbl[i].c1;
      s_ack = tbl[i].ack; s_dat = tbl[i].sdat;
      @(negedge clk);
      e = '{default: 0};
      e.cs = tbl[i].cs; e.to = tbl[i].to; e.err = tbl[i].err;
      e.ack0 = tbl[i].a0; e.ack1 = tbl[i].a1;
      e.md0 = tbl[i].a0 ? tbl[i].rdat : '0;
      e.md1 = tbl[i].a1 ? tbl[i].rdat : '0;
      if (tbl[i].gnt == 1) begin e.addr = 16'h0010; e.dat = 16'hC0DE; e.we = 0; end
      if (tbl[i].gnt == 2) begin e.addr = 16'h0200; e.dat = 16'h1234; e.we = 1; end
      check_all($sformatf("vec%0d", i), e);
      model_eval(me);
      tick();
    end

    // m0 holds cs with a dead slave: back-to-back timeouts, one idle between
    rst = 0; m0_cs = 1; m1_cs = 0; s_ack = 0; n_to = 0; n_ack = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_to += int'(o_timeout); n_ack += int'(o_m0_ack);
      model_eval(me);
      tick();
    end
    m0_cs = 0;
    @(negedge clk);
    chk("seq.timeouts", W'(n_to), W'(2));
    chk("seq.acks", W'(n_ack), W'(2));
    chk("seq.err_sticky", W'(o_err), W'(1));
    model_eval(me);
    tick();

    // randomized traffic against the model
    rst = 1; @(negedge clk); model_eval(me); tick();
    rst = 0;
    req[0] = 0; req[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[m] = 1; ra[m] = W'($urandom); rd[m] = W'($urandom); rw[m] = 1'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) req[m] = 0;
      end
      m0_cs = req[0]; m0_addr = ra[0]; m0_dat = rd[0]; m0_we = rw[0];
      m1_cs = req[1]; m1_addr = ra[1]; m1_dat = rd[1]; m1_we = rw[1];
      s_ack = ($urandom_range(0, 3) == 0);
      s_dat = W'($urandom);
      @(negedge clk);
      model_eval(me);
      check_all($sformatf("rnd%0d", c), me);
      if (me.ack0) req[0] = 0;
      if (me.ack1) req[1] = 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
